// File: rtl/bpred_pkg.sv
// Shared helpers for the branch target buffer. These cover counter encodings,
// saturating arithmetic and PC tag/index slicing.
package bpred_pkg;

  localparam int CNT_MAX_W  = 3;
  localparam int ADDR_MAX_W = 64;

  typedef logic [CNT_MAX_W-1:0]  cnt_t;
  typedef logic [ADDR_MAX_W-1:0] addr_t;

  // Weakly-taken: MSB set, rest clear. Weakly-not-taken: MSB clear, rest set.
  function automatic cnt_t weak_t(input int cnt_bits);
    return cnt_t'(1) << (cnt_bits - 1);
  endfunction

  function automatic cnt_t weak_nt(input int cnt_bits);
    return (cnt_t'(1) << (cnt_bits - 1)) - cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_max(input int cnt_bits);
    return (cnt_t'(1) << cnt_bits) - cnt_t'(1);
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c, input int cnt_bits);
    return (c == cnt_max(cnt_bits)) ? c : c + cnt_t'(1);
  endfunction

  function automatic cnt_t sat_dec(input cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

  function automatic addr_t tag_of(input addr_t addr, input int idx_bits);
    return addr >> (idx_bits + 2);
  endfunction

  function automatic addr_t idx_of(input addr_t addr, input int idx_bits);
    return (addr >> 2) & ((addr_t'(1) << idx_bits) - addr_t'(1));
  endfunction

endpackage

// File: rtl/pred_table_way.sv
// One way of the branch target buffer. It has two combinational read ports
// (fetch lookup, update probe) and one clocked write port with per-field enables.
module pred_table_way
  import bpred_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_BITS = 2,
  localparam int SETS    = 2**IDX_BITS,
  localparam int TAG_W   = ADDR_W - IDX_BITS - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic [IDX_BITS-1:0] ra_idx_i,
  output logic                ra_vld_o,
  output logic [TAG_W-1:0]    ra_tag_o,
  output logic [CNT_BITS-1:0] ra_cnt_o,
  output logic [ADDR_W-1:0]   ra_tgt_o,
  input  logic [IDX_BITS-1:0] rb_idx_i,
  output logic                rb_vld_o,
  output logic [TAG_W-1:0]    rb_tag_o,
  output logic [CNT_BITS-1:0] rb_cnt_o,
  output logic [ADDR_W-1:0]   rb_tgt_o,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_vld_en_i,
  input  logic                wr_tag_en_i,
  input  logic                wr_cnt_en_i,
  input  logic                wr_tgt_en_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [CNT_BITS-1:0] wr_cnt_i,
  input  logic [ADDR_W-1:0]   wr_tgt_i
);

  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(weak_nt(CNT_BITS));

  logic [SETS-1:0]     vld_q;
  logic [TAG_W-1:0]    tag_q [SETS];
  logic [CNT_BITS-1:0] cnt_q [SETS];
  logic [ADDR_W-1:0]   tgt_q [SETS];

  // Stale tag/target words are gated by valid, so they stay out of reset.
  assign ra_vld_o = vld_q[ra_idx_i];
  assign ra_tag_o = tag_q[ra_idx_i];
  assign ra_cnt_o = cnt_q[ra_idx_i];
  assign ra_tgt_o = vld_q[ra_idx_i] ? tgt_q[ra_idx_i] : '0;
  assign rb_vld_o = vld_q[rb_idx_i];
  assign rb_tag_o = tag_q[rb_idx_i];
  assign rb_cnt_o = cnt_q[rb_idx_i];
  assign rb_tgt_o = tgt_q[rb_idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < SETS; s++) cnt_q[s] <= CNT_INIT;
    end else if (clr_i) begin
      vld_q <= '0;
    end else begin
      if (wr_vld_en_i) vld_q[wr_idx_i] <= 1'b1;
      if (wr_cnt_en_i) cnt_q[wr_idx_i] <= wr_cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr_i) begin
      if (wr_tag_en_i) tag_q[wr_idx_i] <= wr_tag_i;
      if (wr_tgt_en_i) tgt_q[wr_idx_i] <= wr_tgt_i;
    end
  end

endmodule

// File: rtl/branch_pred_table.sv
// Branch target buffer with a per-entry saturating direction counter. Lookup has
// zero latency; resolved branches update or allocate with per-set LRU replacement.
module branch_pred_table
  import bpred_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int IDX_BITS = 4,
  parameter int WAYS     = 2,
  parameter int CNT_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc4,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc4,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
);

  localparam int SETS  = 2**IDX_BITS;
  localparam int TAG_W = ADDR_W - IDX_BITS - 2;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("branch_pred_table: WAYS must be 1 or 2");
  end
  if (CNT_BITS < 1 || CNT_BITS > CNT_MAX_W) begin : g_bad_cnt
    $error("branch_pred_table: CNT_BITS must be 1..3");
  end

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;

  assign lk_idx = IDX_BITS'(idx_of(addr_t'(pc4), IDX_BITS));
  assign lk_tag = TAG_W'(tag_of(addr_t'(pc4), IDX_BITS));
  assign up_idx = IDX_BITS'(idx_of(addr_t'(upd_pc4), IDX_BITS));
  assign up_tag = TAG_W'(tag_of(addr_t'(upd_pc4), IDX_BITS));

  logic [WAYS-1:0]                lk_vld, up_vld, lk_match, up_match;
  logic [WAYS-1:0][TAG_W-1:0]     lk_tags, up_tags;
  logic [WAYS-1:0][CNT_BITS-1:0]  lk_cnt, up_cnt;
  logic [WAYS-1:0][ADDR_W-1:0]    lk_tgt, up_tgt;
  logic [WAYS-1:0]                we_vld, we_tag, we_cnt, we_tgt;
  logic [CNT_BITS-1:0]            wr_cnt;
  logic                           clr;

  assign clr = flush;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    pred_table_way #(
      .ADDR_W   (ADDR_W),
      .IDX_BITS (IDX_BITS),
      .CNT_BITS (CNT_BITS)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr),
      .ra_idx_i    (lk_idx),
      .ra_vld_o    (lk_vld[w]),
      .ra_tag_o    (lk_tags[w]),
      .ra_cnt_o    (lk_cnt[w]),
      .ra_tgt_o    (lk_tgt[w]),
      .rb_idx_i    (up_idx),
      .rb_vld_o    (up_vld[w]),
      .rb_tag_o    (up_tags[w]),
      .rb_cnt_o    (up_cnt[w]),
      .rb_tgt_o    (up_tgt[w]),
      .wr_idx_i    (up_idx),
      .wr_vld_en_i (we_vld[w]),
      .wr_tag_en_i (we_tag[w]),
      .wr_cnt_en_i (we_cnt[w]),
      .wr_tgt_en_i (we_tgt[w]),
      .wr_tag_i    (up_tag),
      .wr_cnt_i    (wr_cnt),
      .wr_tgt_i    (upd_target)
    );
    assign lk_match[w] = lk_vld[w] && (lk_tags[w] == lk_tag);
    assign up_match[w] = up_vld[w] && (up_tags[w] == up_tag);
  end

  // Lookup: scan high to low so way 0 wins a (should-be-impossible) double match.
  always_comb begin
    hit        = 1'b0;
    pred_taken = 1'b0;
    target     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_match[w]) begin
        hit        = 1'b1;
        pred_taken = lk_cnt[w][CNT_BITS-1];
        target     = lk_tgt[w];
      end
    end
  end

  // The per-set LRU bit names the way to evict next.
  logic [SETS-1:0] lru_q;
  logic            lru_we;
  logic            lru_d;
  logic            up_hit;
  logic            up_way;
  logic            victim;
  logic            found_inv;

  always_comb begin
    up_hit    = 1'b0;
    up_way    = 1'b0;
    victim    = (WAYS == 1) ? 1'b0 : lru_q[up_idx];
    found_inv = 1'b0;
    we_vld    = '0;
    we_tag    = '0;
    we_cnt    = '0;
    we_tgt    = '0;
    wr_cnt    = '0;
    lru_we    = 1'b0;
    lru_d     = 1'b0;

    for (int w = WAYS - 1; w >= 0; w--) begin
      if (up_match[w]) begin
        up_hit = 1'b1;
        up_way = 1'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!up_vld[w] && !found_inv) begin
        victim    = 1'(w);
        found_inv = 1'b1;
      end
    end

    if (upd_en && !rst && !flush) begin
      if (up_hit) begin
        we_cnt[up_way] = 1'b1;
        we_tgt[up_way] = upd_taken;
        wr_cnt = upd_taken ? CNT_BITS'(sat_inc(cnt_t'(up_cnt[up_way]), CNT_BITS))
                           : CNT_BITS'(sat_dec(cnt_t'(up_cnt[up_way])));
        lru_we = 1'b1;
        lru_d  = ~up_way;
      end else if (upd_taken) begin
        we_vld[victim] = 1'b1;
        we_tag[victim] = 1'b1;
        we_cnt[victim] = 1'b1;
        we_tgt[victim] = 1'b1;
        wr_cnt = CNT_BITS'(weak_t(CNT_BITS));
        lru_we = 1'b1;
        lru_d  = ~victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) lru_q <= '0;
    else if (lru_we)  lru_q[up_idx] <= lru_d;
  end

endmodule

// File: doc/branch_pred_table.md
Name: branch_pred_table

Overview:
Parametrised branch target buffer with direction predictor. Fetch looks up by PC+4 and gets hit, taken-prediction and target in the same cycle. Stage 2 sends the resolved branch outcome back to update the table. Successor to the 16-entry direct-mapped 1-bit table: adds configurable depth, 1/2-way associativity, N-bit saturating counters, valid bits, LRU replacement and flush.

Parameters:
ADDR_W, 32, address width of PC/target
IDX_BITS, 4, set index width; SETS = 2**IDX_BITS; index = pc4[IDX_BITS+1:2]
WAYS, 2, associativity; legal values 1 or 2
CNT_BITS, 2, predictor counter width (1..3); prediction = counter MSB

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc4  in  ADDR_W  fetch PC+4 lookup address
hit  out  1  valid entry with matching tag found for pc4
pred_taken  out  1  predicted direction; 0 when hit=0
target  out  ADDR_W  predicted target; 0 when hit=0
upd_en  in  1  resolved branch update strobe from stage 2
upd_pc4  in  ADDR_W  PC+4 of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual branch target
flush  in  1  invalidate all entries

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Tag = addr[ADDR_W-1:IDX_BITS+2]. Each entry holds valid, tag, counter, target. Each set holds one LRU bit (used only when WAYS=2).
- Lookup is purely combinational from pc4 and current state (0-cycle latency). hit = OR over ways of (valid & tag match). On a hit, pred_taken = counter MSB of the matching way and target = the stored target. On a miss, pred_taken=0 and target=0. Outputs are never X.
- A multi-way match cannot occur, because allocation never duplicates a tag. If one does occur, way 0 wins.
- Update is evaluated at posedge when upd_en=1, on set upd_pc4's index:
  - Hit in a way: counter saturating-increments if upd_taken, otherwise saturating-decrements. Target is overwritten with upd_target only if upd_taken. LRU points to the other way.
  - Miss and upd_taken=1: allocate. Victim is the first invalid way (way 0 first); otherwise the LRU way. Write valid=1, tag, upd_target, and counter = WEAK_T (MSB=1, others 0; e.g. 2'b10). LRU points to the other way.
  - Miss and upd_taken=0: no state change.
  - WAYS=1: the victim is always way 0, and LRU is ignored.
  - CNT_BITS=1: reproduces the legacy 1-bit behaviour.
- No write-to-read bypass. A lookup in the same cycle as an update to the same entry returns pre-update contents. The new contents are visible from the next cycle.
- flush=1: all valid and LRU bits clear at posedge. Any concurrent update is discarded (flush wins).
- rst=1: same as flush. Counters reset to WEAK_NT (MSB=0, others 1; e.g. 2'b01). Tags and targets are not reset. rst dominates flush and upd_en, including mid-stream updates.
- After reset: hit=0, pred_taken=0, target=0 for every pc4.
- Counter arithmetic saturates at 0 and 2**CNT_BITS-1, with no wrap.

Decomposition:
- Package bpred_pkg holds:
  - localparam functions for WEAK_T and WEAK_NT given CNT_BITS
  - sat_inc/sat_dec functions
  - tag/index extraction functions parametrised by ADDR_W and IDX_BITS
- Sub-module pred_table_way: one way's storage (valid/tag/counter/target arrays). It has a combinational read port and a clocked write port with per-field write enables, plus clear-all.
- The top instantiates WAYS copies, plus the LRU array, hit/victim select and counter update logic.

Test Plan:
(Defaults throughout. pc4 0x1004, 0x2004 and 0x3004 all map to index 1, with tags 0x40, 0x80 and 0xC0.)
1. rst then lookup pc4=0x1004 -> hit=0, pred_taken=0, target=0. Same result after rst asserted concurrently with upd_en.
2. upd_en, upd_pc4=0x1004, taken=1, target=0x2000 -> same-cycle lookup hit=0; next cycle hit=1, pred_taken=1 (cnt 2'b10), target=0x2000.
3. Counter saturation on 0x1004: one not-taken update -> hit=1, pred_taken=0. Three taken -> cnt 11, pred 1. Four not-taken -> cnt 00, pred 0, target still 0x2000.
4. LRU: allocate 0x1004 (way0) and 0x2004 (way1), taken-update 0x1004, allocate 0x3004 -> lookups give 0x1004 hit, 0x2004 miss, 0x3004 hit.
5. Not-taken update of unallocated 0x2004 -> no allocation, lookup hit=0. Not-taken update of 0x1004 leaves its target unchanged.
6. flush after entries exist -> all lookups hit=0 next cycle. flush with upd_en (taken, 0x1004) in the same cycle -> next cycle hit=0.
